// File: rtl/imem_loader.sv
// Boot-time instruction-memory loader: takes a length-prefixed little-endian byte
// stream, assembles 32-bit words and writes them to consecutive addresses from 0.
module imem_loader #(
   parameter int ADDR_W = 5,
   parameter int DEPTH  = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              byte_valid,
   input  logic [7:0]        byte_data,
   output logic              byte_ready,
   output logic              wr_en,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [31:0]       wr_data,
   output logic              cpu_hold,
   output logic              done,
   output logic              len_err,
   output logic [ADDR_W:0]   word_count
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LEN,
      S_DATA,
      S_WRITE,
      S_DONE
   } state_t;

   state_t              state;
   state_t              state_nx;
   logic [1:0]          byte_idx;
   logic [23:0]         partial;
   logic [ADDR_W-1:0]   addr_cnt;
   logic [ADDR_W:0]     len_n;
   logic [ADDR_W:0]     wc_inc;
   logic                xfer;
   logic                len_ok;

   // Handshake: a byte moves on a rising edge where byte_valid && byte_ready.
   // byte_ready depends on state only, so it never combinationally follows byte_valid.
   assign byte_ready = (state == S_LEN) || (state == S_DATA);
   assign xfer       = byte_valid && byte_ready;
   assign wr_en      = (state == S_WRITE);
   assign cpu_hold   = (state == S_LEN) || (state == S_DATA) || (state == S_WRITE);
   assign done       = (state == S_DONE);
   assign wc_inc     = word_count + {{ADDR_W{1'b0}}, 1'b1};
   assign len_ok     = (byte_data != 8'd0) && ({24'd0, byte_data} <= 32'(DEPTH));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         S_IDLE:  if (start) state_nx = S_LEN;
         S_LEN:   if (xfer) state_nx = len_ok ? S_DATA : S_DONE;
         S_DATA:  if (xfer && (byte_idx == 2'd3)) state_nx = S_WRITE;
         S_WRITE: state_nx = (wc_inc == len_n) ? S_DONE : S_DATA;
         S_DONE:  state_nx = S_IDLE;
         default: state_nx = S_IDLE;
      endcase
   end

   // wr_addr/wr_data load only when the last byte of a word arrives, so they
   // hold steady outside the write cycle while the next word assembles in partial.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         byte_idx   <= 2'd0;
         partial    <= 24'd0;
         addr_cnt   <= '0;
         len_n      <= '0;
         wr_addr    <= '0;
         wr_data    <= 32'd0;
         len_err    <= 1'b0;
         word_count <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (start) begin
                  len_err    <= 1'b0;
                  word_count <= '0;
                  addr_cnt   <= '0;
                  byte_idx   <= 2'd0;
               end
            end
            S_LEN: begin
               if (xfer) begin
                  if (len_ok) len_n   <= byte_data[ADDR_W:0];
                  else        len_err <= 1'b1;
               end
            end
            S_DATA: begin
               if (xfer) begin
                  case (byte_idx)
                     2'd0: partial[7:0]   <= byte_data;
                     2'd1: partial[15:8]  <= byte_data;
                     2'd2: partial[23:16] <= byte_data;
                     default: begin
                        wr_data <= {byte_data, partial};
                        wr_addr <= addr_cnt;
                     end
                  endcase
                  byte_idx <= byte_idx + 2'd1;
               end
            end
            S_WRITE: begin
               addr_cnt   <= addr_cnt + {{(ADDR_W-1){1'b0}}, 1'b1};
               word_count <= wc_inc;
               byte_idx   <= 2'd0;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: table of load sessions plus hand-written
// reset-in-the-middle sequences; writes are compared against an expected queue.
module tb_imem_loader;
   localparam int ADDR_W = 5;
   localparam int DEPTH  = 32;
   localparam int W      = ADDR_W + 32;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              start = 1'b0;
   logic              byte_valid = 1'b0;
   logic [7:0]        byte_data = 8'd0;
   logic              byte_ready;
   logic              wr_en;
   logic [ADDR_W-1:0] wr_addr;
   logic [31:0]       wr_data;
   logic              cpu_hold;
   logic              done;
   logic              len_err;
   logic [ADDR_W:0]   word_count;

   imem_loader #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
      .clk(clk), .rst_n(rst_n), .start(start),
      .byte_valid(byte_valid), .byte_data(byte_data), .byte_ready(byte_ready),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .cpu_hold(cpu_hold), .done(done), .len_err(len_err), .word_count(word_count)
   );

   // ---------------- clock / cycle counter ----------------
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got time %0t, required < 200000", $time);
      $fatal(1);
   end

   // ---------------- monitor ----------------
   logic [W-1:0] got_q[$];
   int           got_cyc_q[$];
   int           done_cyc_q[$];
   logic         done_hold_q[$];
   logic         pre_hold_q[$];
   logic         prev_hold = 1'b0;

   always @(negedge clk) begin
      if (wr_en) begin
         got_q.push_back({wr_addr, wr_data});
         got_cyc_q.push_back(cyc);
      end
      if (done) begin
         done_cyc_q.push_back(cyc);
         done_hold_q.push_back(cpu_hold);
         pre_hold_q.push_back(prev_hold);
      end
      prev_hold <= cpu_hold;
   end

   // ---------------- scoreboard ----------------
   logic [W-1:0] exp_q[$];
   logic [7:0]   tx_q[$];
   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, required 0x%0h", name, got, exp);
      end
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_byte_ready"}, byte_ready, 0);
      check({tag, "_wr_en"},      wr_en, 0);
      check({tag, "_wr_addr"},    wr_addr, 0);
      check({tag, "_wr_data"},    wr_data, 0);
      check({tag, "_cpu_hold"},   cpu_hold, 0);
      check({tag, "_done"},       done, 0);
      check({tag, "_len_err"},    len_err, 0);
      check({tag, "_word_count"}, word_count, 0);
   endtask

   // ---------------- drivers ----------------
   task automatic drive_bytes(input int gap_max, output bit ok);
      int g;
      int budget;
      ok = 1'b1;
      while (tx_q.size() > 0) begin
         g = (gap_max > 0) ? int'($urandom_range(gap_max, 0)) : 0;
         byte_valid = 1'b0;
         repeat (g) begin
            @(posedge clk);
            #1;
         end
         byte_data  = tx_q.pop_front();
         byte_valid = 1'b1;
         budget = 0;
         @(negedge clk);
         while (!byte_ready && budget < 100) begin
            @(negedge clk);
            budget++;
         end
         if (!byte_ready) begin
            ok = 1'b0;
            tx_q.delete();
         end
         @(posedge clk);
         #1;
      end
      byte_valid = 1'b0;
   endtask

   task automatic pulse_start(output int e0);
      @(posedge clk);
      #1;
      start = 1'b1;
      @(posedge clk);
      #1;
      e0    = cyc;
      start = 1'b0;
   endtask

   // ---------------- session table ----------------
   typedef struct {
      string       name;
      logic [7:0]  len;
      int          nw;
      bit          ramp;
      logic [31:0] w[3];
      int          gap;
      bit          late;
      bit          mid_start;
      bit          exp_err;
      int          done_edge;
   } vec_t;

   function automatic vec_t mk(input string name, input logic [7:0] len, input int nw,
                               input bit ramp, input logic [31:0] w0, input logic [31:0] w1,
                               input logic [31:0] w2, input int gap, input bit late,
                               input bit mid_start, input bit exp_err, input int done_edge);
      vec_t v;
      v.name = name; v.len = len; v.nw = nw; v.ramp = ramp;
      v.w[0] = w0; v.w[1] = w1; v.w[2] = w2;
      v.gap = gap; v.late = late; v.mid_start = mid_start;
      v.exp_err = exp_err; v.done_edge = done_edge;
      return v;
   endfunction

   function automatic logic [31:0] word_of(input vec_t v, input int k);
      return v.ramp ? 32'(k) : v.w[k];
   endfunction

   task automatic run_session(input vec_t v);
      bit          ok;
      int          e0;
      int          wr0;
      int          d0;
      int          b;
      logic [31:0] wd;
      wr0 = got_q.size();
      d0  = done_cyc_q.size();
      exp_q.delete();
      tx_q.delete();
      tx_q.push_back(v.len);
      for (int k = 0; k < v.nw; k++) begin
         wd = word_of(v, k);
         for (int j = 0; j < 4; j++) tx_q.push_back(wd[8*j +: 8]);
         exp_q.push_back({ADDR_W'(k), wd});
      end
      pulse_start(e0);
      if (v.late) begin
         @(posedge clk);
         #1;
      end
      fork
         drive_bytes(v.gap, ok);
         begin
            if (v.mid_start) begin
               repeat (8) @(posedge clk);
               #1;
               start = 1'b1;
               @(posedge clk);
               #1;
               start = 1'b0;
            end
         end
      join
      check({v.name, "_bytes_accepted"}, ok, 1);
      b = 0;
      while (done_cyc_q.size() == d0 && b < 200) begin
         @(posedge clk);
         b++;
      end
      #1;
      check({v.name, "_done_seen"}, done_cyc_q.size() > d0, 1);
      if (done_cyc_q.size() > d0) begin
         if (v.done_edge >= 0)
            check({v.name, "_done_edge"}, done_cyc_q[d0] - e0, v.done_edge);
         check({v.name, "_hold_in_done"}, done_hold_q[d0], 0);
         check({v.name, "_hold_before_done"}, pre_hold_q[d0], 1);
      end
      check({v.name, "_idle_len_err"}, len_err, v.exp_err);
      check({v.name, "_idle_word_count"}, word_count, v.exp_err ? 0 : v.nw);
      check({v.name, "_idle_byte_ready"}, byte_ready, 0);
      check({v.name, "_wr_count"}, got_q.size() - wr0, v.nw);
      for (int k = 0; k < v.nw; k++) begin
         if (wr0 + k < got_q.size()) begin
            check($sformatf("%s_word%0d", v.name, k), got_q[wr0 + k], exp_q[k]);
            if (v.gap == 0)
               check($sformatf("%s_wr_edge%0d", v.name, k), got_cyc_q[wr0 + k] - e0, 5 * k + 5);
         end
      end
      if (v.nw > 0) begin
         check({v.name, "_wr_addr_hold"}, wr_addr, v.nw - 1);
         check({v.name, "_wr_data_hold"}, wr_data, word_of(v, v.nw - 1));
      end
   endtask

   vec_t vecs[6];

   initial begin
      int   e0;
      int   wr0;
      bit   ok;

      vecs[0] = mk("two_word",   8'h02, 2,  0, 32'h01288833, 32'hDEADBEEF, 32'h0,        0, 0, 0, 0, 11);
      vecs[1] = mk("len_zero",   8'h00, 0,  0, 32'h0,        32'h0,        32'h0,        0, 1, 0, 1, 2);
      vecs[2] = mk("len_33",     8'h21, 0,  0, 32'h0,        32'h0,        32'h0,        0, 1, 0, 1, 2);
      vecs[3] = mk("one_word",   8'h01, 1,  0, 32'hCAFEF00D, 32'h0,        32'h0,        0, 0, 0, 0, 6);
      vecs[4] = mk("backpress",  8'h03, 3,  0, 32'hA5A50001, 32'h12345678, 32'h0BADF00D, 3, 0, 1, 0, -1);
      vecs[5] = mk("full_depth", 8'h20, 32, 1, 32'h0,        32'h0,        32'h0,        0, 0, 0, 0, 161);

      // clock / reset
      rst_n = 1'b0;
      #3;
      check_reset_outputs("por");
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < 6; i++) run_session(vecs[i]);

      // reset after two bytes of word 1 of a two-word load
      wr0 = got_q.size();
      tx_q.delete();
      tx_q.push_back(8'h02);
      tx_q.push_back(8'h44); tx_q.push_back(8'h33); tx_q.push_back(8'h22); tx_q.push_back(8'h11);
      tx_q.push_back(8'h99); tx_q.push_back(8'h88);
      pulse_start(e0);
      drive_bytes(0, ok);
      check("midrst_bytes_accepted", ok, 1);
      check("midrst_hold_before", cpu_hold, 1);
      #2;
      rst_n = 1'b0;
      #1;
      check_reset_outputs("midrst");
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (12) @(posedge clk);
      #1;
      check("midrst_wr_count", got_q.size() - wr0, 1);
      if (got_q.size() > wr0) check("midrst_word0", got_q[wr0], {5'd0, 32'h11223344});
      check("midrst_idle_hold", cpu_hold, 0);
      check("midrst_idle_word_count", word_count, 0);

      run_session(mk("after_rst", 8'h01, 1, 0, 32'h5566AA77, 32'h0, 32'h0, 0, 0, 0, 0, 6));

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
